// File: rtl/z80fi_insn_capture_if.sv
// Z80FI retirement record bundle: core event strobes in, captured record out.
// Cycle codes mirror the core's M-cycle classification.
package z80fi_pkg;
    typedef enum logic [2:0] {
        CYCLE_NONE     = 3'd0,
        CYCLE_M1       = 3'd1,
        CYCLE_RDWR_MEM = 3'd2,
        CYCLE_RDWR_IO  = 3'd3,
        CYCLE_INTACK   = 3'd4,
        CYCLE_INTERNAL = 3'd5
    } cycle_e;
endpackage

interface z80fi_insn_capture_if #(
    parameter int TCYC_W = 4
);
    logic              insn_start;
    logic [15:0]       ip_in;
    logic              mcycle_start;
    logic [2:0]        mcycle_type;
    logic              tstate_tick;
    logic              insn_byte_valid;
    logic [7:0]        insn_byte;
    logic              mem_rd_valid;
    logic [15:0]       mem_rd_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_valid;
    logic [15:0]       mem_wr_addr;
    logic [7:0]        mem_wr_data;
    logic              insn_done;

    logic              z80fi_valid;
    logic [31:0]       z80fi_insn;
    logic [2:0]        z80fi_insn_len;
    logic [15:0]       z80fi_reg_ip_in;
    logic [15:0]       z80fi_bus_raddr;
    logic [7:0]        z80fi_bus_rdata;
    logic [15:0]       z80fi_bus_waddr;
    logic [7:0]        z80fi_bus_wdata;
    logic              z80fi_bus_rd;
    logic              z80fi_bus_wr;
    logic [2:0]        z80fi_mcycle_type1;
    logic [2:0]        z80fi_mcycle_type2;
    logic [2:0]        z80fi_mcycle_type3;
    logic [2:0]        z80fi_mcycle_type4;
    logic [2:0]        z80fi_mcycle_type5;
    logic [2:0]        z80fi_mcycle_type6;
    logic [TCYC_W-1:0] z80fi_tcycles1;
    logic [TCYC_W-1:0] z80fi_tcycles2;
    logic [TCYC_W-1:0] z80fi_tcycles3;
    logic [TCYC_W-1:0] z80fi_tcycles4;
    logic [TCYC_W-1:0] z80fi_tcycles5;
    logic [TCYC_W-1:0] z80fi_tcycles6;
    logic              z80fi_overflow;

    modport master (
        output insn_start, ip_in, mcycle_start, mcycle_type,
        output tstate_tick, insn_byte_valid, insn_byte,
        output mem_rd_valid, mem_rd_addr, mem_rd_data,
        output mem_wr_valid, mem_wr_addr, mem_wr_data, insn_done,
        input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_reg_ip_in,
        input  z80fi_bus_raddr, z80fi_bus_rdata,
        input  z80fi_bus_waddr, z80fi_bus_wdata,
        input  z80fi_bus_rd, z80fi_bus_wr,
        input  z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3,
        input  z80fi_mcycle_type4, z80fi_mcycle_type5, z80fi_mcycle_type6,
        input  z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3,
        input  z80fi_tcycles4, z80fi_tcycles5, z80fi_tcycles6,
        input  z80fi_overflow
    );

    modport slave (
        input  insn_start, ip_in, mcycle_start, mcycle_type,
        input  tstate_tick, insn_byte_valid, insn_byte,
        input  mem_rd_valid, mem_rd_addr, mem_rd_data,
        input  mem_wr_valid, mem_wr_addr, mem_wr_data, insn_done,
        output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_reg_ip_in,
        output z80fi_bus_raddr, z80fi_bus_rdata,
        output z80fi_bus_waddr, z80fi_bus_wdata,
        output z80fi_bus_rd, z80fi_bus_wr,
        output z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3,
        output z80fi_mcycle_type4, z80fi_mcycle_type5, z80fi_mcycle_type6,
        output z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3,
        output z80fi_tcycles4, z80fi_tcycles5, z80fi_tcycles6,
        output z80fi_overflow
    );
endinterface

// File: rtl/z80fi_insn_capture.sv
// Accumulates one instruction's Z80FI record from per-T-state strobes
// and publishes it with a one-cycle valid pulse at retirement.
module z80fi_insn_capture
    import z80fi_pkg::*;
#(
    parameter int MAX_MCYCLES = 6,
    parameter int TCYC_W      = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    z80fi_insn_capture_if.slave cap
);
    typedef enum logic {
        S_IDLE,
        S_CAPTURE
    } state_t;

    localparam int IDX_W = $clog2(MAX_MCYCLES + 2);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_MCYCLES);
    localparam logic [IDX_W-1:0] IDX_OVF = IDX_W'(MAX_MCYCLES + 1);
    localparam logic [TCYC_W-1:0] T_SAT = '1;

    typedef struct packed {
        logic [3:0][7:0]                    insn;
        logic [2:0]                         len;
        logic [15:0]                        ip;
        logic                               rd;
        logic [15:0]                        raddr;
        logic [7:0]                         rdata;
        logic                               wr;
        logic [15:0]                        waddr;
        logic [7:0]                         wdata;
        logic [MAX_MCYCLES-1:0][2:0]        typ;
        logic [MAX_MCYCLES-1:0][TCYC_W-1:0] tcyc;
        logic                               ovf;
    } rec_t;

    localparam rec_t REC_RST = '{
        typ:     {MAX_MCYCLES{CYCLE_NONE}},
        default: '0
    };

    state_t           r_state;
    state_t           w_state;
    rec_t             r_acc;
    rec_t             w_acc;
    rec_t             r_rec;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx;
    logic             r_valid;
    logic             w_active;
    logic             w_commit;

    assign w_active = cap.insn_start || (r_state == S_CAPTURE);
    assign w_commit = cap.insn_done && (r_state == S_CAPTURE);

    always_comb begin
        w_state = r_state;
        if (cap.insn_start) begin
            w_state = S_CAPTURE;
        end else if (w_commit) begin
            w_state = S_IDLE;
        end
    end

    // Events of an insn_start cycle land on the freshly cleared record.
    always_comb begin
        w_acc = r_acc;
        w_idx = r_idx;
        if (cap.insn_start) begin
            w_acc        = REC_RST;
            w_acc.ip     = cap.ip_in;
            w_acc.typ[0] = cap.mcycle_type;
            w_idx        = IDX_W'(1);
        end
        if (w_active) begin
            if (cap.mcycle_start && !cap.insn_start) begin
                if (w_idx >= IDX_MAX) begin
                    w_acc.ovf = 1'b1;
                    w_idx     = IDX_OVF;
                end else begin
                    w_idx = w_idx + IDX_W'(1);
                    for (int k = 0; k < MAX_MCYCLES; k++) begin
                        if (w_idx == IDX_W'(k + 1)) begin
                            w_acc.typ[k] = cap.mcycle_type;
                        end
                    end
                end
            end
            for (int k = 0; k < MAX_MCYCLES; k++) begin
                if (cap.tstate_tick && (w_idx == IDX_W'(k + 1))) begin
                    if (w_acc.tcyc[k] == T_SAT) begin
                        w_acc.ovf = 1'b1;
                    end else begin
                        w_acc.tcyc[k] = w_acc.tcyc[k] + TCYC_W'(1);
                    end
                end
            end
            if (cap.insn_byte_valid) begin
                if (w_acc.len < 3'd4) begin
                    w_acc.insn[w_acc.len[1:0]] = cap.insn_byte;
                    w_acc.len = w_acc.len + 3'd1;
                end else begin
                    w_acc.ovf = 1'b1;
                end
            end
            if (cap.mem_rd_valid && !w_acc.rd) begin
                w_acc.rd    = 1'b1;
                w_acc.raddr = cap.mem_rd_addr;
                w_acc.rdata = cap.mem_rd_data;
            end
            if (cap.mem_wr_valid && !w_acc.wr) begin
                w_acc.wr    = 1'b1;
                w_acc.waddr = cap.mem_wr_addr;
                w_acc.wdata = cap.mem_wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_acc   <= REC_RST;
            r_idx   <= '0;
            r_rec   <= REC_RST;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_acc   <= w_acc;
            r_idx   <= w_idx;
            r_valid <= w_commit;
            // A coinciding start steals this cycle's events for the new insn.
            if (w_commit) begin
                r_rec <= cap.insn_start ? r_acc : w_acc;
            end
        end
    end

    assign cap.z80fi_valid        = r_valid;
    assign cap.z80fi_insn         = r_rec.insn;
    assign cap.z80fi_insn_len     = r_rec.len;
    assign cap.z80fi_reg_ip_in    = r_rec.ip;
    assign cap.z80fi_bus_raddr    = r_rec.raddr;
    assign cap.z80fi_bus_rdata    = r_rec.rdata;
    assign cap.z80fi_bus_waddr    = r_rec.waddr;
    assign cap.z80fi_bus_wdata    = r_rec.wdata;
    assign cap.z80fi_bus_rd       = r_rec.rd;
    assign cap.z80fi_bus_wr       = r_rec.wr;
    assign cap.z80fi_mcycle_type1 = r_rec.typ[0];
    assign cap.z80fi_mcycle_type2 = r_rec.typ[1];
    assign cap.z80fi_mcycle_type3 = r_rec.typ[2];
    assign cap.z80fi_mcycle_type4 = r_rec.typ[3];
    assign cap.z80fi_mcycle_type5 = r_rec.typ[4];
    assign cap.z80fi_mcycle_type6 = r_rec.typ[5];
    assign cap.z80fi_tcycles1     = r_rec.tcyc[0];
    assign cap.z80fi_tcycles2     = r_rec.tcyc[1];
    assign cap.z80fi_tcycles3     = r_rec.tcyc[2];
    assign cap.z80fi_tcycles4     = r_rec.tcyc[3];
    assign cap.z80fi_tcycles5     = r_rec.tcyc[4];
    assign cap.z80fi_tcycles6     = r_rec.tcyc[5];
    assign cap.z80fi_overflow     = r_rec.ovf;
endmodule

// File: tb/tb_z80fi_insn_capture.sv
// Scoreboard bench: instructions described abstractly, spread over cycles,
// expected records derived from the description and matched on each pulse.
module tb_z80fi_insn_capture;
    import z80fi_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    z80fi_insn_capture_if #(.TCYC_W(4)) cap ();

    z80fi_insn_capture #(
        .MAX_MCYCLES(6),
        .TCYC_W(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cap(cap)
    );

    typedef struct packed {
        logic [31:0]     insn;
        logic [2:0]      len;
        logic [15:0]     ip;
        logic            rd;
        logic [15:0]     raddr;
        logic [7:0]      rdata;
        logic            wr;
        logic [15:0]     waddr;
        logic [7:0]      wdata;
        logic [5:0][2:0] mt;
        logic [5:0][3:0] tc;
        logic            ovf;
    } rec_t;

    typedef struct packed {
        logic        start;
        logic        mst;
        logic [2:0]  mtype;
        logic [15:0] ip;
        logic        tick;
        logic        bv;
        logic [7:0]  b;
        logic        rv;
        logic [15:0] ra;
        logic [7:0]  rdat;
        logic        wv;
        logic [15:0] wa;
        logic [7:0]  wd;
        logic        done;
    } cyc_t;

    int   checks = 0;
    int   errors = 0;
    rec_t expq[$];
    rec_t last_rec;
    rec_t rst_rec;
    rec_t mon_a;
    rec_t mon_e;
    cyc_t cq[$];
    bit   pend_done = 1'b0;

    logic [15:0] d_ip;
    logic [2:0]  d_mt[$];
    int          d_mk[$];
    logic [7:0]  d_b[$];
    logic [15:0] d_ra[$];
    logic [7:0]  d_rd[$];
    logic [15:0] d_wa[$];
    logic [7:0]  d_wd[$];

    function automatic rec_t actual();
        rec_t r;
        r.insn  = cap.z80fi_insn;
        r.len   = cap.z80fi_insn_len;
        r.ip    = cap.z80fi_reg_ip_in;
        r.rd    = cap.z80fi_bus_rd;
        r.raddr = cap.z80fi_bus_raddr;
        r.rdata = cap.z80fi_bus_rdata;
        r.wr    = cap.z80fi_bus_wr;
        r.waddr = cap.z80fi_bus_waddr;
        r.wdata = cap.z80fi_bus_wdata;
        r.mt    = {cap.z80fi_mcycle_type6, cap.z80fi_mcycle_type5,
                   cap.z80fi_mcycle_type4, cap.z80fi_mcycle_type3,
                   cap.z80fi_mcycle_type2, cap.z80fi_mcycle_type1};
        r.tc    = {cap.z80fi_tcycles6, cap.z80fi_tcycles5,
                   cap.z80fi_tcycles4, cap.z80fi_tcycles3,
                   cap.z80fi_tcycles2, cap.z80fi_tcycles1};
        r.ovf   = cap.z80fi_overflow;
        return r;
    endfunction

    // Record implied by the instruction description alone.
    function automatic rec_t model();
        rec_t r = '0;
        r.mt = {6{CYCLE_NONE}};
        r.ip = d_ip;
        for (int i = 0; i < d_b.size(); i++) begin
            if (i < 4) r.insn[8*i +: 8] = d_b[i];
            else r.ovf = 1'b1;
        end
        r.len = 3'((d_b.size() > 4) ? 4 : d_b.size());
        for (int k = 0; k < d_mt.size(); k++) begin
            if (k < 6) begin
                r.mt[k] = d_mt[k];
                r.tc[k] = 4'((d_mk[k] > 15) ? 15 : d_mk[k]);
                if (d_mk[k] > 15) r.ovf = 1'b1;
            end else begin
                r.ovf = 1'b1;
            end
        end
        if (d_ra.size() > 0) begin
            r.rd = 1'b1; r.raddr = d_ra[0]; r.rdata = d_rd[0];
        end
        if (d_wa.size() > 0) begin
            r.wr = 1'b1; r.waddr = d_wa[0]; r.wdata = d_wd[0];
        end
        return r;
    endfunction

    function automatic cyc_t junk_cap();
        cyc_t c = '0;
        c.mtype = 3'($urandom_range(0, 7));
        c.ip    = 16'($urandom);
        c.b     = 8'($urandom);
        c.ra    = 16'($urandom);
        c.rdat  = 8'($urandom);
        c.wa    = 16'($urandom);
        c.wd    = 8'($urandom);
        return c;
    endfunction

    function automatic cyc_t junk_idle();
        cyc_t c = junk_cap();
        c.mst  = 1'($urandom_range(0, 1));
        c.tick = 1'($urandom_range(0, 1));
        c.bv   = 1'($urandom_range(0, 1));
        c.rv   = 1'($urandom_range(0, 1));
        c.wv   = 1'($urandom_range(0, 1));
        c.done = 1'($urandom_range(0, 1));
        return c;
    endfunction

    task automatic clear_desc(input logic [15:0] ip);
        d_ip = ip;
        d_mt.delete(); d_mk.delete(); d_b.delete();
        d_ra.delete(); d_rd.delete(); d_wa.delete(); d_wd.delete();
    endtask

    task automatic add_mc(input logic [2:0] t, input int n);
        d_mt.push_back(t);
        d_mk.push_back(n);
    endtask

    task automatic build();
        cyc_t c;
        int   need;
        int   j;
        cq.delete();
        for (int m = 0; m < d_mt.size(); m++) begin
            for (int t = 0; t < d_mk[m]; t++) begin
                if (t > 0 && $urandom_range(0, 3) == 0) cq.push_back(junk_cap());
                c = junk_cap();
                c.tick = 1'b1;
                c.mst = (t == 0);
                c.start = (m == 0 && t == 0);
                if (t == 0) c.mtype = d_mt[m];
                if (c.start) c.ip = d_ip;
                cq.push_back(c);
            end
        end
        need = d_b.size();
        if (d_ra.size() > need) need = d_ra.size();
        if (d_wa.size() > need) need = d_wa.size();
        while (cq.size() < need) cq.push_back(junk_cap());
        j = 0;
        for (int i = 0; i < cq.size(); i++) begin
            if (j < d_b.size() &&
                ((d_b.size() - j) >= (cq.size() - i) || $urandom_range(0, 1) == 1)) begin
                c = cq[i]; c.bv = 1'b1; c.b = d_b[j]; cq[i] = c; j++;
            end
        end
        j = 0;
        for (int i = 0; i < cq.size(); i++) begin
            if (j < d_ra.size() &&
                ((d_ra.size() - j) >= (cq.size() - i) || $urandom_range(0, 2) == 0)) begin
                c = cq[i]; c.rv = 1'b1; c.ra = d_ra[j]; c.rdat = d_rd[j]; cq[i] = c; j++;
            end
        end
        j = 0;
        for (int i = 0; i < cq.size(); i++) begin
            if (j < d_wa.size() &&
                ((d_wa.size() - j) >= (cq.size() - i) || $urandom_range(0, 2) == 0)) begin
                c = cq[i]; c.wv = 1'b1; c.wa = d_wa[j]; c.wd = d_wd[j]; cq[i] = c; j++;
            end
        end
    endtask

    task automatic drive(input cyc_t c);
        cap.insn_start      = c.start;
        cap.ip_in           = c.ip;
        cap.mcycle_start    = c.mst;
        cap.mcycle_type     = c.mtype;
        cap.tstate_tick     = c.tick;
        cap.insn_byte_valid = c.bv;
        cap.insn_byte       = c.b;
        cap.mem_rd_valid    = c.rv;
        cap.mem_rd_addr     = c.ra;
        cap.mem_rd_data     = c.rdat;
        cap.mem_wr_valid    = c.wv;
        cap.mem_wr_addr     = c.wa;
        cap.mem_wr_data     = c.wd;
        cap.insn_done       = c.done;
        @(posedge clk);
        #1;
    endtask

    task automatic run_insn(input bit overlap_next);
        cyc_t c;
        expq.push_back(model());
        build();
        if (pend_done) begin
            c = cq[0]; c.done = 1'b1; cq[0] = c;
        end
        if (!overlap_next) begin
            c = cq[cq.size()-1]; c.done = 1'b1; cq[cq.size()-1] = c;
        end
        pend_done = overlap_next;
        foreach (cq[i]) drive(cq[i]);
        if (!overlap_next) repeat ($urandom_range(0, 3)) drive(junk_idle());
    endtask

    task automatic rand_insn(input bit overlap_next);
        int nm;
        int nb;
        clear_desc(16'($urandom));
        nm = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(1, 6);
        for (int m = 0; m < nm; m++) begin
            int r = $urandom_range(0, 11);
            int tk = (r == 0) ? 15 : (r == 1) ? 16 : $urandom_range(1, 5);
            add_mc((m == 0) ? 3'(CYCLE_M1) : 3'($urandom_range(1, 5)), tk);
        end
        nb = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 4);
        for (int i = 0; i < nb; i++) d_b.push_back(8'($urandom));
        repeat ($urandom_range(0, 2)) begin
            d_ra.push_back(16'($urandom)); d_rd.push_back(8'($urandom));
        end
        repeat ($urandom_range(0, 2)) begin
            d_wa.push_back(16'($urandom)); d_wd.push_back(8'($urandom));
        end
        run_insn(overlap_next);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            last_rec = rst_rec;
        end else begin
            mon_a = actual();
            checks++;
            if (cap.z80fi_valid) begin
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got record %h, required no pulse", mon_a);
                end else begin
                    mon_e = expq.pop_front();
                    if (mon_a !== mon_e) begin
                        errors++;
                        $display("FAIL record: got %h required %h", mon_a, mon_e);
                    end
                end
                last_rec = mon_a;
            end else if (mon_a !== last_rec) begin
                errors++;
                $display("FAIL hold: got %h required %h", mon_a, last_rec);
            end
        end
    end

    initial begin
        cyc_t c;
        rst_rec = '0;
        rst_rec.mt = {6{CYCLE_NONE}};
        drive('0);
        #12;
        checks++;
        if (actual() !== rst_rec || cap.z80fi_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h valid %b required %h valid 0",
                     actual(), cap.z80fi_valid, rst_rec);
        end
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;

        repeat (6) drive(junk_idle());

        clear_desc(16'h0100);
        add_mc(CYCLE_M1, 4);
        repeat (3) add_mc(CYCLE_RDWR_MEM, 3);
        d_b.push_back(8'h3A); d_b.push_back(8'h34); d_b.push_back(8'h12);
        d_ra.push_back(16'h1234); d_rd.push_back(8'h5A);
        run_insn(1'b0);

        clear_desc(16'h0200);
        add_mc(CYCLE_M1, 4);
        d_b.push_back(8'h00);
        run_insn(1'b1);
        clear_desc(16'h0201);
        add_mc(CYCLE_M1, 4);
        d_b.push_back(8'h00);
        run_insn(1'b0);

        clear_desc(16'h0300);
        add_mc(CYCLE_M1, 20);
        repeat (6) add_mc(CYCLE_RDWR_MEM, 1);
        for (int i = 0; i < 5; i++) d_b.push_back(8'(8'hD0 + i));
        run_insn(1'b0);

        clear_desc(16'h0400);
        add_mc(CYCLE_M1, 4);
        repeat (3) add_mc(CYCLE_RDWR_MEM, 3);
        d_b.push_back(8'hED);
        d_ra.push_back(16'h2000); d_rd.push_back(8'h11);
        d_ra.push_back(16'h2001); d_rd.push_back(8'h22);
        d_wa.push_back(16'h3000); d_wd.push_back(8'h77);
        run_insn(1'b0);

        repeat (3) drive('0);
        clear_desc(16'h0500);
        add_mc(CYCLE_M1, 4);
        d_b.push_back(8'h01);
        build();
        for (int i = 0; i < 3; i++) drive(cq[i]);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (actual() !== rst_rec || cap.z80fi_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_capture: got %h valid %b required %h valid 0",
                     actual(), cap.z80fi_valid, rst_rec);
        end
        @(posedge clk); @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        c = '0; c.done = 1'b1;
        drive(c);
        repeat (3) drive('0);
        checks++;
        if (actual() !== rst_rec) begin
            errors++;
            $display("FAIL after_reset_done: got %h required %h", actual(), rst_rec);
        end

        for (int n = 0; n < 60; n++) begin
            rand_insn((n < 59) && ($urandom_range(0, 2) == 0));
        end

        repeat (4) drive('0);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_valid: got %0d records outstanding required 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
